// File: rtl/vending_controller_param.sv
// ----------------------------------------------------------------------------
// vending_controller_param
//
// Purpose
//   Parametrised vending controller with N product slots, a price and a stock
//   count per slot, cash (coin) or card payment, a registered vend pulse and
//   greedy coin change. It sits between the coin/card front-end and the
//   dispenser / coin-return drivers.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   index, select       slot selection and 1-cycle purchase request
//   pay_card            1 = card mode, 0 = cash mode
//   card_balance        balance of the presented card (cents)
//   nickel/dime/quarter/dollar  1-cycle coin pulses (5/10/25/100 cents)
//   cancel              refund request
//   cost_flat           slot i price at [i*PRICE_W +: PRICE_W]
//   inv_load, inv_flat  load stock table (slot i at [i*INV_W +: INV_W])
//   credit              current cash credit
//   inv_out             live stock table, same packing as inv_flat
//   dispensed, disp_index, card_debit   vend pulse with slot and card charge
//   change_valid, quart, dim, nick      change pulse with coin counts
//   sold_out, insufficient, coin_reject 1-cycle status pulses
//   busy                high while a vend or change is in progress
//   state_dbg           current FSM state (IDLE=0, VEND=1, CHANGE=2)
//
// Pulse semantics
//   Every input strobe (coins, select, cancel, inv_load) is sampled on a
//   single rising edge; there is no back-pressure. Every output pulse is high
//   for exactly one clock cycle; its qualified data (disp_index, card_debit,
//   quart/dim/nick) is valid only in that cycle and reads 0 otherwise.
// ----------------------------------------------------------------------------
module vending_controller_param #(
    parameter int NUM_PRODUCTS = 8,
    parameter int IDX_W        = 3,
    parameter int PRICE_W      = 9,
    parameter int INV_W        = 3,
    parameter int COIN_W       = 5,
    parameter int MAX_CREDIT   = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IDX_W-1:0]              index,
    input  logic                          select,
    input  logic                          pay_card,
    input  logic [PRICE_W-1:0]            card_balance,
    input  logic                          nickel,
    input  logic                          dime,
    input  logic                          quarter,
    input  logic                          dollar,
    input  logic                          cancel,
    input  logic [NUM_PRODUCTS*PRICE_W-1:0] cost_flat,
    input  logic                          inv_load,
    input  logic [NUM_PRODUCTS*INV_W-1:0] inv_flat,
    output logic [PRICE_W-1:0]            credit,
    output logic [NUM_PRODUCTS*INV_W-1:0] inv_out,
    output logic                          dispensed,
    output logic [IDX_W-1:0]              disp_index,
    output logic [PRICE_W-1:0]            card_debit,
    output logic                          change_valid,
    output logic [COIN_W-1:0]             quart,
    output logic [COIN_W-1:0]             dim,
    output logic [COIN_W-1:0]             nick,
    output logic                          sold_out,
    output logic                          insufficient,
    output logic                          coin_reject,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    // Coin values and the credit ceiling are held one bit wider than a price
    // so that credit + coins can be compared against the cap without wrap.
    localparam logic [PRICE_W:0] V_NICKEL  = (PRICE_W+1)'(5);
    localparam logic [PRICE_W:0] V_DIME    = (PRICE_W+1)'(10);
    localparam logic [PRICE_W:0] V_QUARTER = (PRICE_W+1)'(25);
    localparam logic [PRICE_W:0] V_DOLLAR  = (PRICE_W+1)'(100);
    localparam logic [PRICE_W:0] CREDIT_CAP = (PRICE_W+1)'(MAX_CREDIT);

    // Divisors for the greedy change split.
    localparam logic [PRICE_W-1:0] DIV_25 = PRICE_W'(25);
    localparam logic [PRICE_W-1:0] DIV_10 = PRICE_W'(10);
    localparam logic [PRICE_W-1:0] DIV_5  = PRICE_W'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [INV_W-1:0]   stock_q [NUM_PRODUCTS];
    logic [INV_W-1:0]   stock_d [NUM_PRODUCTS];
    logic [IDX_W-1:0]   idx_q, idx_d;       // slot being vended
    logic [PRICE_W-1:0] cost_q, cost_d;     // price captured at selection
    logic               card_q, card_d;     // payment mode captured at selection
    logic               sold_out_q, sold_out_d;
    logic               insuff_q, insuff_d;
    logic               reject_q, reject_d;

    // ------------------------------------------------------------------
    // Selected-slot lookup. An index beyond the slot count reads as an
    // empty slot, so it can only ever produce a sold_out pulse.
    // ------------------------------------------------------------------
    logic [PRICE_W-1:0] sel_cost;
    logic [INV_W-1:0]   sel_stock;

    always_comb begin
        sel_cost  = '0;
        sel_stock = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (index == IDX_W'(i)) begin
                sel_cost  = cost_flat[i*PRICE_W +: PRICE_W];
                sel_stock = stock_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Coin summation for the current cycle
    // ------------------------------------------------------------------
    logic             coin_any;
    logic [PRICE_W:0] coin_value;
    logic [PRICE_W:0] credit_sum;

    assign coin_any   = nickel | dime | quarter | dollar;
    assign coin_value = (nickel  ? V_NICKEL  : '0)
                      + (dime    ? V_DIME    : '0)
                      + (quarter ? V_QUARTER : '0)
                      + (dollar  ? V_DOLLAR  : '0);
    assign credit_sum = {1'b0, credit_q} + coin_value;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        stock_d    = stock_q;
        idx_d      = idx_q;
        cost_d     = cost_q;
        card_d     = card_q;
        sold_out_d = 1'b0;
        insuff_d   = 1'b0;
        reject_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Coins of one cycle are accepted or rejected as a group.
                if (coin_any) begin
                    if (pay_card || (credit_sum > CREDIT_CAP)) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = credit_sum[PRICE_W-1:0];
                    end
                end

                if (inv_load) begin
                    for (int i = 0; i < NUM_PRODUCTS; i++) begin
                        stock_d[i] = inv_flat[i*INV_W +: INV_W];
                    end
                end

                // Cancel takes priority over select. The purchase check sees
                // credit_d, i.e. coins arriving with select count toward it.
                if (cancel) begin
                    if (credit_d != '0) begin
                        state_d = S_CHANGE;
                    end
                end else if (select) begin
                    if (sel_stock == '0) begin
                        sold_out_d = 1'b1;
                    end else if (pay_card ? (card_balance >= sel_cost)
                                          : (credit_d >= sel_cost)) begin
                        state_d = S_VEND;
                        idx_d   = index;
                        cost_d  = sel_cost;
                        card_d  = pay_card;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                reject_d = coin_any;
                // Stock was checked non-zero before entering VEND.
                stock_d[idx_q] = stock_q[idx_q] - INV_W'(1);
                if (!card_q) begin
                    credit_d = credit_q - cost_q;
                end
                state_d = S_CHANGE;
            end

            S_CHANGE: begin
                reject_d = coin_any;
                credit_d = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            idx_q      <= '0;
            cost_q     <= '0;
            card_q     <= 1'b0;
            sold_out_q <= 1'b0;
            insuff_q   <= 1'b0;
            reject_q   <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            idx_q      <= idx_d;
            cost_q     <= cost_d;
            card_q     <= card_d;
            sold_out_q <= sold_out_d;
            insuff_q   <= insuff_d;
            reject_q   <= reject_d;
            stock_q    <= stock_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Vend and change outputs decode directly from registered
    // state, so they are glitch-free and clear together on reset.
    // ------------------------------------------------------------------
    logic               in_vend;
    logic [PRICE_W-1:0] rem_25;
    logic [PRICE_W-1:0] rem_10;

    assign in_vend = (state_q == S_VEND);
    assign rem_25  = credit_q % DIV_25;
    assign rem_10  = rem_25 % DIV_10;

    assign dispensed    = in_vend;
    assign disp_index   = in_vend ? idx_q : '0;
    assign card_debit   = (in_vend && card_q) ? cost_q : '0;

    // Greedy split; any residue below 5 cents is dropped.
    assign change_valid = (state_q == S_CHANGE) && (credit_q != '0);
    assign quart        = change_valid ? COIN_W'(credit_q / DIV_25) : '0;
    assign dim          = change_valid ? COIN_W'(rem_25 / DIV_10)   : '0;
    assign nick         = change_valid ? COIN_W'(rem_10 / DIV_5)    : '0;

    assign credit       = credit_q;
    assign sold_out     = sold_out_q;
    assign insufficient = insuff_q;
    assign coin_reject  = reject_q;
    assign busy         = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign state_dbg    = state_q;

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_inv_out
        assign inv_out[g*INV_W +: INV_W] = stock_q[g];
    end

endmodule
